// File: rtl/btb_pkg.sv
// Shared types and sizing for the BTB write-port scheduler.
// Includes the resolved-branch to BTB-entry slicing helper.
package btb_pkg;

    localparam int BTB_SIZE    = 32;
    localparam int IDX_BITS    = 5;
    localparam int TAG_BITS    = 5;
    localparam int TARGET_LEN  = 10;
    localparam int QDEPTH      = 4;
    localparam int QPTR_BITS   = $clog2(QDEPTH);
    localparam int STARVE_LIM  = 8;
    localparam int STARVE_BITS = $clog2(STARVE_LIM);

    localparam logic [IDX_BITS-1:0]    WALK_LAST  = IDX_BITS'(BTB_SIZE - 1);
    localparam logic [QPTR_BITS:0]     QCNT_FULL  = (QPTR_BITS + 1)'(QDEPTH);
    localparam logic [STARVE_BITS-1:0] STARVE_MAX = STARVE_BITS'(STARVE_LIM - 1);

    typedef enum logic {
        FLUSH = 1'b0,
        RUN   = 1'b1
    } sched_state_e;

    typedef struct packed {
        logic [IDX_BITS-1:0]   idx;
        logic [TAG_BITS-1:0]   tag;
        logic [TARGET_LEN-1:0] target;
        logic                  wvalid;
    } btb_upd_t;

    // A not-taken result writes wvalid=0 so the stale entry is dropped.
    function automatic btb_upd_t make_upd(input logic [63:0] pc,
                                          input logic [63:0] target,
                                          input logic        taken);
        btb_upd_t u;
        u.idx    = pc[IDX_BITS-1:0];
        u.tag    = pc[IDX_BITS+TAG_BITS-1:IDX_BITS];
        u.target = target[TARGET_LEN-1:0];
        u.wvalid = taken;
        return u;
    endfunction

endpackage

// File: rtl/btb_upd_fifo.sv
// Small in-order queue of pending BTB updates; head is presented combinationally.
// A count register separates full from empty since the pointers wrap mod QDEPTH.
module btb_upd_fifo
    import btb_pkg::*;
(
    input  logic     clk,
    input  logic     reset,
    input  logic     clear,
    input  logic     push,
    input  logic     pop,
    input  btb_upd_t din,
    output btb_upd_t head,
    output logic     full,
    output logic     empty
);

    btb_upd_t               mem [QDEPTH];
    logic [QPTR_BITS-1:0]   wr_ptr;
    logic [QPTR_BITS-1:0]   rd_ptr;
    logic [QPTR_BITS:0]     count;
    logic                   do_push;
    logic                   do_pop;

    assign full    = (count == QCNT_FULL);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + {{QPTR_BITS{1'b0}}, do_push} - {{QPTR_BITS{1'b0}}, do_pop};
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/btb_update_sched.sv
// BTB write-port owner: queues resolved branches, arbitrates writes against
// fetch lookups on the single-ported array, and runs the invalidate-all walk.
//
// state | meaning
// FLUSH | walking every index writing valid=0; lookups and enqueues blocked
// RUN   | lookups have priority; queued updates drain in idle slots or on starvation
module btb_update_sched
    import btb_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush_req,
    input  logic                  lookup_req,
    output logic                  lookup_grant,
    input  logic                  res_valid,
    input  logic [63:0]           res_pc,
    input  logic [63:0]           res_target,
    input  logic                  res_taken,
    output logic                  res_ready,
    output logic                  btb_we,
    output logic [IDX_BITS-1:0]   btb_widx,
    output logic [TAG_BITS-1:0]   btb_wtag,
    output logic [TARGET_LEN-1:0] btb_wtarget,
    output logic                  btb_wvalid,
    output logic                  busy
);

    sched_state_e           state, state_nxt;
    logic [IDX_BITS-1:0]    walk_idx, walk_idx_nxt;
    logic [STARVE_BITS-1:0] starve_cnt, starve_cnt_nxt;
    btb_upd_t               head;
    btb_upd_t               enq;
    logic                   q_full, q_empty, q_push, q_pop, q_clear;
    logic                   preempt;

    assign enq     = make_upd(res_pc, res_target, res_taken);
    assign preempt = (starve_cnt == STARVE_MAX) && !q_empty;

    btb_upd_fifo u_fifo (
        .clk   (clk),
        .reset (reset),
        .clear (q_clear),
        .push  (q_push),
        .pop   (q_pop),
        .din   (enq),
        .head  (head),
        .full  (q_full),
        .empty (q_empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= FLUSH;
            walk_idx   <= '0;
            starve_cnt <= '0;
        end else begin
            state      <= state_nxt;
            walk_idx   <= walk_idx_nxt;
            starve_cnt <= starve_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        walk_idx_nxt   = walk_idx;
        starve_cnt_nxt = '0;
        q_push         = 1'b0;
        q_pop          = 1'b0;
        q_clear        = 1'b0;
        lookup_grant   = 1'b0;
        res_ready      = 1'b0;
        busy           = 1'b1;
        btb_we         = 1'b0;
        btb_widx       = '0;
        btb_wtag       = '0;
        btb_wtarget    = '0;
        btb_wvalid     = 1'b0;
        if (!reset) begin
            case (state)
                FLUSH: begin
                    btb_we   = 1'b1;
                    btb_widx = walk_idx;
                    if (flush_req) begin
                        walk_idx_nxt = '0;
                    end else if (walk_idx == WALK_LAST) begin
                        state_nxt    = RUN;
                        walk_idx_nxt = '0;
                    end else begin
                        walk_idx_nxt = walk_idx + 1'b1;
                    end
                end
                RUN: begin
                    busy        = 1'b0;
                    res_ready   = !q_full;
                    btb_widx    = head.idx;
                    btb_wtag    = head.tag;
                    btb_wtarget = head.target;
                    btb_wvalid  = head.wvalid;
                    if (flush_req) begin
                        // Queue is discarded, so no queued entry may reach the array this cycle.
                        lookup_grant = lookup_req;
                        q_clear      = 1'b1;
                        state_nxt    = FLUSH;
                        walk_idx_nxt = '0;
                    end else begin
                        if (preempt) begin
                            btb_we = 1'b1;
                            q_pop  = 1'b1;
                        end else if (lookup_req) begin
                            lookup_grant = 1'b1;
                        end else if (!q_empty) begin
                            btb_we = 1'b1;
                            q_pop  = 1'b1;
                        end
                        if (!preempt && q_full && lookup_req)
                            starve_cnt_nxt = starve_cnt + 1'b1;
                        q_push = res_valid && !q_full;
                    end
                end
                default: state_nxt = FLUSH;
            endcase
        end
    end

endmodule

// File: tb/tb_btb_update_sched.sv
// Scoreboard bench for btb_update_sched: a queue-based reference model predicts
// each cycle's control outputs and BTB writes; a negedge monitor pops and compares.
module tb_btb_update_sched;

    logic        clk;
    logic        reset;
    logic        flush_req;
    logic        lookup_req;
    logic        lookup_grant;
    logic        res_valid;
    logic [63:0] res_pc;
    logic [63:0] res_target;
    logic        res_taken;
    logic        res_ready;
    logic        btb_we;
    logic [4:0]  btb_widx;
    logic [4:0]  btb_wtag;
    logic [9:0]  btb_wtarget;
    logic        btb_wvalid;
    logic        busy;

    btb_update_sched dut (
        .clk          (clk),
        .reset        (reset),
        .flush_req    (flush_req),
        .lookup_req   (lookup_req),
        .lookup_grant (lookup_grant),
        .res_valid    (res_valid),
        .res_pc       (res_pc),
        .res_target   (res_target),
        .res_taken    (res_taken),
        .res_ready    (res_ready),
        .btb_we       (btb_we),
        .btb_widx     (btb_widx),
        .btb_wtag     (btb_wtag),
        .btb_wtarget  (btb_wtarget),
        .btb_wvalid   (btb_wvalid),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int idx;
        int tag;
        int target;
        bit wvalid;
    } wr_t;

    typedef struct {
        bit rst;
        bit we;
        bit grant;
        bit ready;
        bit busy;
    } ctl_t;

    wr_t  wr_q[$];
    ctl_t ctl_q[$];

    // Reference model state
    wr_t  pend[$];
    bit   flushing;
    int   walk;
    int   starve;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        ctl_t c;
        wr_t  w;
        bit   full;
        bit   pre;
        c = '{rst: 1'b0, we: 1'b0, grant: 1'b0, ready: 1'b0, busy: 1'b1};
        if (reset) begin
            c.rst = 1'b1;
            pend.delete();
            flushing = 1'b1;
            walk     = 0;
            starve   = 0;
        end else if (flushing) begin
            c.we = 1'b1;
            w = '{idx: walk, tag: 0, target: 0, wvalid: 1'b0};
            wr_q.push_back(w);
            if (flush_req)       walk = 0;
            else if (walk == 31) begin flushing = 1'b0; walk = 0; end
            else                 walk++;
            starve = 0;
        end else begin
            c.busy  = 1'b0;
            c.ready = (pend.size() < 4);
            full    = (pend.size() == 4);
            if (flush_req) begin
                c.grant = lookup_req;
                pend.delete();
                flushing = 1'b1;
                walk     = 0;
                starve   = 0;
            end else begin
                pre = (starve == 7) && (pend.size() > 0);
                if (pre || (!lookup_req && pend.size() > 0)) begin
                    c.we = 1'b1;
                    wr_q.push_back(pend.pop_front());
                end else if (lookup_req) begin
                    c.grant = 1'b1;
                end
                starve = (!pre && full && lookup_req) ? starve + 1 : 0;
                if (res_valid && c.ready) begin
                    w.idx    = int'(res_pc % 64'd32);
                    w.tag    = int'((res_pc / 64'd32) % 64'd32);
                    w.target = int'(res_target % 64'd1024);
                    w.wvalid = res_taken;
                    pend.push_back(w);
                end
            end
        end
        ctl_q.push_back(c);
    endtask

    task automatic cyc(input bit rst, input bit fl, input bit lk, input bit rv,
                       input logic [63:0] pc, input logic [63:0] tg, input bit tk);
        reset      = rst;
        flush_req  = fl;
        lookup_req = lk;
        res_valid  = rv;
        res_pc     = pc;
        res_target = tg;
        res_taken  = tk;
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input bit lk);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, lk, 1'b0, 64'd0, 64'd0, 1'b0);
    endtask

    // Monitor: every cycle consumes one control prediction; writes consume write predictions.
    initial begin
        ctl_t e;
        wr_t  w;
        forever begin
            @(negedge clk);
            if (ctl_q.size() > 0) begin
                e = ctl_q.pop_front();
                chk("busy", longint'(busy), longint'(e.busy));
                chk("lookup_grant", longint'(lookup_grant), longint'(e.grant));
                chk("res_ready", longint'(res_ready), longint'(e.ready));
                chk("btb_we", longint'(btb_we), longint'(e.we));
                if (e.rst) begin
                    chk("reset_widx", longint'(btb_widx), 0);
                    chk("reset_wtag", longint'(btb_wtag), 0);
                    chk("reset_wtarget", longint'(btb_wtarget), 0);
                    chk("reset_wvalid", longint'(btb_wvalid), 0);
                end
                if (e.we && wr_q.size() > 0) begin
                    w = wr_q.pop_front();
                    if (btb_we) begin
                        chk("btb_widx", longint'(btb_widx), longint'(w.idx));
                        chk("btb_wtag", longint'(btb_wtag), longint'(w.tag));
                        chk("btb_wtarget", longint'(btb_wtarget), longint'(w.target));
                        chk("btb_wvalid", longint'(btb_wvalid), longint'(w.wvalid));
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit fl, lk, rv;
        int lk_pct;
        reset = 1'b1; flush_req = 1'b0; lookup_req = 1'b0; res_valid = 1'b0;
        res_pc = '0; res_target = '0; res_taken = 1'b0;
        @(posedge clk);
        #1;

        // 1: reset, then full invalidate walk
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 64'd0, 64'd0, 1'b0);
        idle(34, 1'b0);

        // 2: taken branch written the cycle after enqueue
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 64'h3A4, 64'h155, 1'b1);
        idle(3, 1'b0);

        // 3: starvation under constant lookup
        for (int i = 0; i < 4; i++)
            cyc(1'b0, 1'b0, 1'b1, 1'b1, 64'h1000 + 64'(i * 36), 64'h2A0 + 64'(i), 1'b1);
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 64'h5555, 64'h77, 1'b1);
        idle(20, 1'b1);
        idle(6, 1'b0);

        // 4: not-taken invalidates its index
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 64'h07, 64'hABC, 1'b0);
        idle(3, 1'b0);

        // 5: queued updates discarded by flush
        for (int i = 0; i < 3; i++)
            cyc(1'b0, 1'b0, 1'b1, 1'b1, 64'h40 + 64'(i), 64'h300 + 64'(i), 1'b1);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 64'd0, 64'd0, 1'b0);
        idle(36, 1'b0);

        // 6: flush restarts a walk in progress at idx 20
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 64'd0, 64'd0, 1'b0);
        idle(20, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 64'd0, 64'd0, 1'b0);
        idle(34, 1'b0);

        // Randomised traffic with varying lookup pressure, rare flushes and one reset
        for (int i = 0; i < 700; i++) begin
            lk_pct = (i / 100) % 2 == 0 ? 90 : 40;
            fl = ($urandom_range(99) < 2);
            lk = ($urandom_range(99) < lk_pct);
            rv = ($urandom_range(99) < 60);
            if (i == 350 || i == 351)
                cyc(1'b1, 1'b0, lk, rv, {$urandom(), $urandom()}, {$urandom(), $urandom()}, 1'b1);
            else
                cyc(1'b0, fl, lk, rv, {$urandom(), $urandom()}, {$urandom(), $urandom()},
                    1'($urandom_range(1)));
        end
        idle(40, 1'b0);

        @(negedge clk);
        #1;
        chk("pending_writes_left", longint'(wr_q.size()), 0);
        chk("pending_ctl_left", longint'(ctl_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
